// File: rtl/rf_mp_sb_pkg.sv
// Common defaults and per-bit pending-state operation for the multi-port register file.
package rf_mp_sb_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 1;

  typedef enum logic [1:0] {
    PEND_HOLD,
    PEND_SET,
    PEND_CLR
  } pend_op_e;
endpackage

// File: rtl/rf_defs.vh
// Shared sizing and port-slice helpers for the register-file blocks.
`ifndef RF_DEFS_VH
`define RF_DEFS_VH

`define RF_AW(n) (((n) > 1) ? $clog2(n) : 1)
`define RF_SL(k, w) ((k) * (w)) +: (w)

`endif

// File: rtl/rf_scoreboard.sv
// Pending-write bits per register with an incrementally maintained popcount.
`include "rf_defs.vh"

module rf_scoreboard
  import rf_mp_sb_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = `RF_AW(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NREGS-1:0] i_wmask,
  input  logic             i_rsv_en,
  input  logic [AW-1:0]    i_rsv_addr,
  input  logic             i_flush,
  output logic [NREGS-1:0] o_pend,
  output logic [AW:0]      o_pend_cnt
);
  localparam logic [AW:0] MAXC = (AW+1)'(NREGS - 1);

  logic [NREGS-1:0] rmask, pend_nxt, clr_vec;
  logic [AW:0]      clr_n, cnt_nxt;
  logic             set_new;
  pend_op_e         op;

  always_comb begin
    rmask = '0;
    if (i_rsv_en) rmask[i_rsv_addr] = 1'b1;
    rmask[0] = 1'b0;
  end

  // Reserve beats a same-cycle write; flush beats both.
  always_comb begin
    pend_nxt = o_pend;
    op       = PEND_HOLD;
    for (int r = 0; r < NREGS; r++) begin
      op = rmask[r] ? PEND_SET : (i_wmask[r] ? PEND_CLR : PEND_HOLD);
      case (op)
        PEND_SET: pend_nxt[r] = 1'b1;
        PEND_CLR: pend_nxt[r] = 1'b0;
        default:  pend_nxt[r] = o_pend[r];
      endcase
    end
    if (i_flush) pend_nxt = '0;
  end

  always_comb begin
    set_new = |(rmask & ~o_pend);
    clr_vec = o_pend & i_wmask & ~rmask;
    clr_n   = '0;
    for (int r = 0; r < NREGS; r++) clr_n = clr_n + {{AW{1'b0}}, clr_vec[r]};
    cnt_nxt = o_pend_cnt + {{AW{1'b0}}, set_new} - clr_n;
    if (cnt_nxt > MAXC) cnt_nxt = MAXC;
    if (i_flush) cnt_nxt = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pend     <= '0;
      o_pend_cnt <= '0;
    end else begin
      o_pend     <= pend_nxt;
      o_pend_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/rf_mp_sb.sv
// Multi-port register file with optional write-to-read bypass and a pending-write scoreboard.
`include "rf_defs.vh"

module rf_mp_sb
  import rf_mp_sb_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREGS     = NREGS_DEF,
  parameter int NRD       = NRD_DEF,
  parameter int NWR       = NWR_DEF,
  parameter int BYPASS_EN = 0,
  localparam int AW       = `RF_AW(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NRD*AW-1:0]   i_rs_raddr,
  output logic [NRD*XLEN-1:0] o_rs_rdata,
  output logic [NRD-1:0]      o_rs_busy,
  input  logic [NWR-1:0]      i_rd_wen,
  input  logic [NWR*AW-1:0]   i_rd_waddr,
  input  logic [NWR*XLEN-1:0] i_rd_wdata,
  input  logic                i_rsv_en,
  input  logic [AW-1:0]       i_rsv_addr,
  input  logic                i_flush,
  output logic [AW:0]         o_pend_cnt
);
  logic [NREGS-1:0][XLEN-1:0] mem;
  logic [NREGS-1:0]           pend, wmask;

  always_comb begin
    wmask = '0;
    for (int w = 0; w < NWR; w++)
      if (i_rd_wen[w]) wmask[i_rd_waddr[`RF_SL(w, AW)]] = 1'b1;
    wmask[0] = 1'b0;
  end

  // Later ports assign last, so the highest-numbered port wins a conflict.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem <= '0;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (i_rd_wen[w] && (i_rd_waddr[`RF_SL(w, AW)] != '0))
          mem[i_rd_waddr[`RF_SL(w, AW)]] <= i_rd_wdata[`RF_SL(w, XLEN)];
    end
  end

  rf_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wmask    (wmask),
    .i_rsv_en   (i_rsv_en),
    .i_rsv_addr (i_rsv_addr),
    .i_flush    (i_flush),
    .o_pend     (pend),
    .o_pend_cnt (o_pend_cnt)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;

    assign ra = i_rs_raddr[`RF_SL(k, AW)];

    // A forwarded value is no longer pending unless re-reserved this cycle.
    always_comb begin
      rd = mem[ra];
      rb = pend[ra];
      if (BYPASS_EN != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (i_rd_wen[w] && (i_rd_waddr[`RF_SL(w, AW)] == ra)) begin
            rd = i_rd_wdata[`RF_SL(w, XLEN)];
            rb = i_rsv_en && (i_rsv_addr == ra);
          end
        end
      end
      if (ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign o_rs_rdata[`RF_SL(k, XLEN)] = rd;
    assign o_rs_busy[k]                = rb;
  end
endmodule

// File: tb/tb_rf_mp_sb.sv
// Directed bench: two DUTs (bypass off/on) sharing stimulus, checked against a behavioural model.
module tb_rf_mp_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic                clk = 1'b0, rst_n = 1'b0;
  logic [NRD*AW-1:0]   raddr = '0;
  logic [NWR-1:0]      wen = '0;
  logic [NWR*AW-1:0]   waddr = '0;
  logic [NWR*XLEN-1:0] wdata = '0;
  logic                rsv_en = 1'b0, flush = 1'b0;
  logic [AW-1:0]       rsv_addr = '0;

  logic [NRD*XLEN-1:0] a_rdata, b_rdata;
  logic [NRD-1:0]      a_busy, b_busy;
  logic [AW:0]         a_cnt, b_cnt;

  int errors = 0, checks = 0;

  logic [XLEN-1:0] mreg  [NREGS];
  bit              mpend [NREGS];

  rf_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS_EN(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rs_raddr(raddr), .o_rs_rdata(a_rdata), .o_rs_busy(a_busy),
    .i_rd_wen(wen), .i_rd_waddr(waddr), .i_rd_wdata(wdata), .i_rsv_en(rsv_en),
    .i_rsv_addr(rsv_addr), .i_flush(flush), .o_pend_cnt(a_cnt));

  rf_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS_EN(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rs_raddr(raddr), .o_rs_rdata(b_rdata), .o_rs_busy(b_busy),
    .i_rd_wen(wen), .i_rd_waddr(waddr), .i_rd_wdata(wdata), .i_rsv_en(rsv_en),
    .i_rsv_addr(rsv_addr), .i_flush(flush), .o_pend_cnt(b_cnt));

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: register array + pending flags, updated from the rules at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        mreg[r]  = '0;
        mpend[r] = 1'b0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        bit wr_hit, rsv_hit;
        wr_hit  = 1'b0;
        rsv_hit = rsv_en && (int'(rsv_addr) == r);
        for (int w = 0; w < NWR; w++)
          if (wen[w] && int'(waddr[w*AW +: AW]) == r) begin
            wr_hit  = 1'b1;
            mreg[r] = wdata[w*XLEN +: XLEN];
          end
        if (flush)        mpend[r] = 1'b0;
        else if (rsv_hit) mpend[r] = 1'b1;
        else if (wr_hit)  mpend[r] = 1'b0;
      end
    end
  end

  function automatic int mcnt();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(mpend[r]);
    return n;
  endfunction

  function automatic void exp_rd(input bit byp, input int k, output logic [31:0] d, output logic b);
    int a = int'(raddr[k*AW +: AW]);
    d = mreg[a];
    b = mpend[a];
    if (byp)
      for (int w = 0; w < NWR; w++)
        if (wen[w] && int'(waddr[w*AW +: AW]) == a) begin
          d = wdata[w*XLEN +: XLEN];
          b = rsv_en && (int'(rsv_addr) == a);
        end
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    logic [31:0] d;
    logic        b;
    for (int k = 0; k < NRD; k++) begin
      exp_rd(1'b0, k, d, b);
      check($sformatf("a_rdata%0d", k), a_rdata[k*XLEN +: XLEN], d);
      check($sformatf("a_busy%0d", k), 32'(a_busy[k]), 32'(b));
      exp_rd(1'b1, k, d, b);
      check($sformatf("b_rdata%0d", k), b_rdata[k*XLEN +: XLEN], d);
      check($sformatf("b_busy%0d", k), 32'(b_busy[k]), 32'(b));
    end
    check("a_cnt", 32'(a_cnt), 32'(mcnt()));
    check("b_cnt", 32'(b_cnt), 32'(mcnt()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    wen = '0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic wr(input int w, input int a, input logic [31:0] d);
    wen[w] = 1'b1;
    waddr[w*AW +: AW]   = AW'(a);
    wdata[w*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int k, input int a);
    raddr[k*AW +: AW] = AW'(a);
  endtask

  task automatic rsv(input int a);
    rsv_en = 1'b1;
    rsv_addr = AW'(a);
  endtask

  function automatic logic [31:0] rda(input int k); return a_rdata[k*XLEN +: XLEN]; endfunction
  function automatic logic [31:0] rdb(input int k); return b_rdata[k*XLEN +: XLEN]; endfunction

  initial begin
    tick(); tick();
    rd(0, 5); #2;
    check("rst_x5", rda(0), 32'h0);
    check("rst_cnt", 32'(a_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // bypass
    wr(0, 3, 32'hA5A5); rd(0, 3); #2;
    check("byp_same_cycle", rdb(0), 32'hA5A5);
    check("nobyp_old", rda(0), 32'h0);
    tick(); #2;
    check("nobyp_after_edge", rda(0), 32'hA5A5);

    // write conflict and x0
    wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7); #2;
    check("conf_byp", rdb(0), 32'h22);
    tick(); #2;
    check("conf_a", rda(0), 32'h22);
    check("conf_b", rdb(0), 32'h22);
    wr(0, 0, 32'hFF); rd(1, 0); #2;
    check("x0_byp", rdb(1), 32'h0);
    tick(); #2;
    check("x0_a", rda(1), 32'h0);

    // scoreboard
    rsv(4); rd(0, 4); tick(); #2;
    check("sb_busy", 32'(a_busy[0]), 32'h1);
    check("sb_cnt", 32'(a_cnt), 32'h1);
    wr(0, 4, 32'h44); rsv(4); #2;
    check("sb_rsv_wr_byp_busy", 32'(b_busy[0]), 32'h1);
    tick(); #2;
    check("sb_rsv_wr_busy", 32'(a_busy[0]), 32'h1);
    check("sb_rsv_wr_cnt", 32'(a_cnt), 32'h1);
    wr(0, 4, 32'h45); #2;
    check("sb_wr_byp_busy", 32'(b_busy[0]), 32'h0);
    tick(); #2;
    check("sb_wr_busy", 32'(a_busy[0]), 32'h0);
    check("sb_wr_cnt", 32'(a_cnt), 32'h0);

    // flush
    rsv(1); tick(); rsv(2); tick(); rsv(3); tick(); #2;
    check("fl_cnt3", 32'(a_cnt), 32'h3);
    flush = 1'b1; rsv(9); tick();
    rd(0, 9); rd(1, 1); #2;
    check("fl_cnt0", 32'(a_cnt), 32'h0);
    check("fl_busy9", 32'(a_busy[0]), 32'h0);
    check("fl_busy1", 32'(a_busy[1]), 32'h0);
    rd(0, 2); rd(1, 3); #1;
    check("fl_busy2", 32'(a_busy[0]), 32'h0);
    check("fl_busy3", 32'(a_busy[1]), 32'h0);
    rd(0, 4); #1;
    check("fl_keeps_data", rda(0), 32'h45);

    // saturation
    for (int r = 1; r < NREGS; r++) begin
      rsv(r); tick();
    end
    #2;
    check("sat_cnt", 32'(a_cnt), 32'(NREGS - 1));
    rsv(1); tick(); #2;
    check("sat_rersv", 32'(b_cnt), 32'(NREGS - 1));
    flush = 1'b1; tick();

    // asynchronous reset mid-cycle
    wr(0, 5, 32'hDEADBEEF); rsv(6); tick();
    rd(0, 5); #2;
    check("pre_rst_x5", rda(0), 32'hDEADBEEF);
    check("pre_rst_cnt", 32'(a_cnt), 32'h1);
    rst_n = 1'b0; #1;
    check("rst_mid_x5_a", rda(0), 32'h0);
    check("rst_mid_x5_b", rdb(0), 32'h0);
    check("rst_mid_cnt", 32'(a_cnt), 32'h0);
    wr(1, 5, 32'h1234); rsv(5); tick(); #2;
    check("rst_ign_x5", rda(0), 32'h0);
    check("rst_ign_cnt", 32'(a_cnt), 32'h0);
    tick();
    rst_n = 1'b1; tick(); #2;
    check("post_rst_x5", rda(0), 32'h0);
    check("post_rst_cnt", 32'(b_cnt), 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
